// File: rtl/matmul_result_display_if.sv
// Result-set handshake between the 2x2 matrix-multiply stage and the
// display block.
//
// Handshake: a set {in_error, in_res} transfers on a rising clk edge where
// in_valid and in_ready are both 1. The source must hold in_valid, in_error
// and in_res steady until that edge. in_ready depends only on sink state,
// never on in_valid.
//
// Signals:
//   in_valid  source -> sink  result set presented this cycle
//   in_error  source -> sink  upstream range error for the presented set
//   in_res    source -> sink  {r22, r21, r12, r11}, 4 bits each, unsigned
//   in_ready  sink -> source  sink can accept a result set
interface matmul_result_display_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_error;
  logic [15:0] in_res;

  modport master (
    output in_valid,
    output in_error,
    output in_res,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_error,
    input  in_res,
    output in_ready
  );
endinterface

// File: rtl/matmul_result_display.sv
// Shows a 2x2 product matrix on one seven-segment digit. Each accepted set
// is shown as r11, r12, r21, r22, each held DWELL_CYCLES cycles and followed
// by GAP_CYCLES blank cycles. A set flagged with in_error shows 'E' for
// DWELL_CYCLES cycles instead. A dash is shown while idle.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   up         result-set handshake (slave side; in_ready is driven here)
//   seg_out    segments {g,f,e,d,c,b,a}, active-high, registered
//   dp_out     decimal point, set while r11 is shown, registered
//   idx_out    index of the element shown (0=r11 .. 3=r22), registered
//   busy       sequence in progress (inverse of in_ready), registered
//   dbg_state  current FSM state (0=IDLE, 1=SHOW, 2=GAP, 3=ERR)
module matmul_result_display #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES   = 250,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  matmul_result_display_if.slave        up,
  output logic [6:0]                    seg_out,
  output logic                          dp_out,
  output logic [1:0]                    idx_out,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_E     = 7'h79;

  // Terminal counts; the state changes on the edge where the counter
  // equals these, so a state lasts exactly limit cycles.
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   =
    CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      cap_q, cap_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [3:0]       elem;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Next state, counter, index and capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = 2'd0;
        // ready_q is 1 throughout IDLE, so in_valid alone marks a transfer.
        if (up.in_valid) begin
          cap_d   = up.in_res;
          state_d = up.in_error ? ERR : SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (HAS_GAP) begin
            state_d = GAP;
          end else if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else begin
            state_d = IDLE;
            idx_d   = 2'd0;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q != 2'd3) begin
            state_d = SHOW;
            idx_d   = idx_q + 2'd1;
          end else begin
            state_d = IDLE;
            idx_d   = 2'd0;
          end
        end
      end
      ERR: begin
        idx_d = 2'd0;
        if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // line up with the state they describe (one cycle after a capture edge).
  always_comb begin
    elem = 4'h0;
    case (idx_d)
      2'd0: elem = cap_d[3:0];
      2'd1: elem = cap_d[7:4];
      2'd2: elem = cap_d[11:8];
      default: elem = cap_d[15:12];
    endcase
  end

  always_comb begin
    seg_d   = SEG_DASH;
    dp_d    = 1'b0;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    case (state_d)
      SHOW: begin
        seg_d = hex_seg(elem);
        dp_d  = (idx_d == 2'd0);
      end
      GAP:     seg_d = SEG_BLANK;
      ERR:     seg_d = SEG_E;
      default: seg_d = SEG_DASH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      idx_q   <= 2'd0;
      seg_q   <= SEG_DASH;
      dp_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign up.in_ready = ready_q;
  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign idx_out     = idx_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule
